// File: rtl/irq_ctrl_pkg.sv
// Shared bus widths, response codes, register map and CLAIM layout
// for the memory-mapped interrupt controller.
package irq_ctrl_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_IDLE  = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK    = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERROR = 2'd2;

  // Word index of each register (byte offset / 4).
  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_PENDING = 3'd2,
    REG_EDGE    = 3'd3,
    REG_CLAIM   = 3'd4
  } reg_sel_t;

  localparam int REG_WINDOW      = 'h14;
  localparam int CTRL_GEN_BIT    = 0;
  localparam int CLAIM_VALID_BIT = 31;
  localparam int CLAIM_ID_W      = 5;

  function automatic logic [3:0] lane_mask(
    input logic [MEM_COUNT_W-1:0] cnt,
    input logic [1:0]             a
  );
    logic [3:0] m;
    m = 4'b0000;
    case (cnt)
      MEM_COUNT_BYTE: m = 4'b0001 << a;
      MEM_COUNT_HALF: m = 4'b0011 << a;
      MEM_COUNT_WORD: m = 4'b1111;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [WORD_W-1:0] byte_expand(
    input logic [3:0] l
  );
    return {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest set index wins.
// Ports: req (N sources), id (winning index, 0 if none), valid (any set).
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [4:0]   id,
  output logic         valid
);

  always_comb begin
    id    = '0;
    valid = |req;
    // Walk downward so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 5'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: CTRL/ENABLE/PENDING/EDGE/CLAIM.
// Ports: clk, reset, bus request (addr/wr_data/wr_en/count), registered
// response (rd_data/code), irq sources, registered o_irq and o_irq_id.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_START = '0,
  parameter int                NUM_SRC    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [WORD_W-1:0]      i_req_wr_data,
  input  logic                   i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_req_count,
  output logic [WORD_W-1:0]      o_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_res_code,
  input  logic [NUM_SRC-1:0]     i_irq_src,
  output logic                   o_irq,
  output logic [4:0]             o_irq_id
);

  logic               gen;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] prev_src;

  logic [ADDR_W-1:0]  off;
  logic               req;
  logic               in_win;
  logic               misal;
  logic               err;
  logic               wr;
  logic               rd;
  reg_sel_t           sel;
  logic [WORD_W-1:0]  wmask;
  logic [WORD_W-1:0]  wbits;
  logic [WORD_W-1:0]  rdata;

  logic               gen_nx;
  logic [NUM_SRC-1:0] en_nx;
  logic [NUM_SRC-1:0] edge_nx;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] src_set;
  logic [NUM_SRC-1:0] active;
  logic [4:0]         act_id;
  logic               act_valid;

  // Window check on the offset; addresses below ADDR_START wrap
  // to a large offset and fall out of range.
  assign off    = i_req_addr - ADDR_START;
  assign req    = i_req_count != MEM_COUNT_NONE;
  assign in_win = off < ADDR_W'(REG_WINDOW);
  assign misal  = (i_req_count == MEM_COUNT_HALF && off[0])
               || (i_req_count == MEM_COUNT_WORD && off[1:0] != 2'b00);
  assign sel    = reg_sel_t'(off[4:2]);
  assign err    = req && (!in_win || misal
               || (i_req_wr_en && sel == REG_CLAIM));
  assign wr     = req && !err && i_req_wr_en;
  assign rd     = req && !err && !i_req_wr_en;

  assign wmask  = byte_expand(lane_mask(i_req_count, off[1:0]));
  assign wbits  = i_req_wr_data & wmask;

  always_comb begin
    gen_nx   = gen;
    en_nx    = enable;
    edge_nx  = edge_mode;
    pend_clr = '0;
    if (wr) begin
      case (sel)
        REG_CTRL:
          if (wmask[CTRL_GEN_BIT]) gen_nx = wbits[CTRL_GEN_BIT];
        REG_ENABLE:
          en_nx = (enable & ~wmask[NUM_SRC-1:0])
                | wbits[NUM_SRC-1:0];
        REG_PENDING:
          pend_clr = wbits[NUM_SRC-1:0];
        REG_EDGE:
          edge_nx = (edge_mode & ~wmask[NUM_SRC-1:0])
                  | wbits[NUM_SRC-1:0];
        default: ;
      endcase
    end
  end

  // Edge sources fire on 0->1 against the last sample; level sources
  // fire every cycle they are high. Sets beat a same-cycle clear.
  assign src_set = (edge_mode & i_irq_src & ~prev_src)
                 | (~edge_mode & i_irq_src);
  assign active  = pending & enable;

  irq_prio_enc #(
    .N (NUM_SRC)
  ) u_enc (
    .req   (active),
    .id    (act_id),
    .valid (act_valid)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CTRL:    rdata[CTRL_GEN_BIT]  = gen;
      REG_ENABLE:  rdata[NUM_SRC-1:0]   = enable;
      REG_PENDING: rdata[NUM_SRC-1:0]   = pending;
      REG_EDGE:    rdata[NUM_SRC-1:0]   = edge_mode;
      REG_CLAIM: begin
        // o_irq already equals GEN & |active, one cycle delayed.
        rdata[CLAIM_VALID_BIT]  = o_irq;
        rdata[CLAIM_ID_W-1:0]   = o_irq_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen           <= 1'b0;
      enable        <= '0;
      pending       <= '0;
      edge_mode     <= '0;
      prev_src      <= '0;
      o_irq         <= 1'b0;
      o_irq_id      <= '0;
      o_res_rd_data <= '0;
      o_res_code    <= MEM_CODE_IDLE;
    end else begin
      gen           <= gen_nx;
      enable        <= en_nx;
      edge_mode     <= edge_nx;
      pending       <= (pending & ~pend_clr) | src_set;
      prev_src      <= i_irq_src;
      o_irq         <= gen & act_valid;
      o_irq_id      <= act_id;
      o_res_rd_data <= rd ? rdata : '0;
      if (!req)     o_res_code <= MEM_CODE_IDLE;
      else if (err) o_res_code <= MEM_CODE_ERROR;
      else          o_res_code <= MEM_CODE_OK;
    end
  end

  // Bits above NUM_SRC of the masked write word are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{wbits, wmask};

endmodule
